// File: rtl/freq_meter_pkg.sv
// Shared constants and the BCD decade step used by the frequency meter.
package freq_meter_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int GATE_CYCLES_DEF = 100;

  // One decade step: hold, increment, or roll over (or stick at 9 when saturating)
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] q,
                                                 input logic inc,
                                                 input logic sat);
    logic [BCD_W-1:0] r;
    if (!inc) begin
      r = q;
    end else if (q >= BCD_MAX) begin
      r = sat ? BCD_MAX : 4'd0;
    end else begin
      r = q + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// Single decade of the edge counter; carries when it sees an increment at 9.
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = inc & (q == BCD_MAX);

  // Decade register: cleared at window end, otherwise stepped
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else begin
      q <= bcd_step(q, inc, sat);
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter with packed BCD result latch.
// Optional feature: define FREQ_METER_OVF_EN for a saturating count with overflow flag.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int DIGITS      = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    sig_in,
  output logic [BCD_W*DIGITS-1:0] freq_bcd,
  output logic                    valid,
  output logic                    ovf
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic                    s1_r;
  logic                    s2_r;
  logic                    rise_s;
  logic [GW-1:0]           gate_r;
  logic                    terminal_s;
  logic                    sat_s;
  logic [DIGITS-1:0]       inc_s;
  logic [DIGITS-1:0]       carry_s;
  logic [BCD_W*DIGITS-1:0] cnt_s;
  logic [BCD_W*DIGITS-1:0] next_cnt_s;

  // Two-flop synchroniser for the asynchronous input
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
    end
  end

  assign rise_s = s1_r & ~s2_r;

  // Gate window counter, wraps after the terminal cycle
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_r <= '0;
    end else if (gate_r == GATE_LAST) begin
      gate_r <= '0;
    end else begin
      gate_r <= gate_r + GW'(1);
    end
  end

  assign terminal_s = (gate_r == GATE_LAST);
  assign inc_s[0]   = rise_s;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr    (terminal_s),
      .inc    (inc_s[i]),
      .sat    (sat_s),
      .q      (cnt_s[i*BCD_W +: BCD_W]),
      .carry  (carry_s[i])
    );
    // Same step the digit applies, so the latch sees the terminal-cycle edge
    assign next_cnt_s[i*BCD_W +: BCD_W] = bcd_step(cnt_s[i*BCD_W +: BCD_W], inc_s[i], sat_s);
    if (i < DIGITS - 1) begin : g_chain
      assign inc_s[i+1] = carry_s[i];
    end
  end

`ifdef FREQ_METER_OVF_EN
  logic ovf_bit_r;
  logic ovf_hit_s;

  assign sat_s     = (cnt_s == {DIGITS{BCD_MAX}});
  // Carry out of the top decade only happens on a rise at all-nines
  assign ovf_hit_s = carry_s[DIGITS-1];

  // Sticky in-window overflow, handed to the output at window end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ovf_bit_r <= 1'b0;
      ovf       <= 1'b0;
    end else if (terminal_s) begin
      ovf       <= ovf_bit_r | ovf_hit_s;
      ovf_bit_r <= 1'b0;
    end else begin
      ovf_bit_r <= ovf_bit_r | ovf_hit_s;
      ovf       <= ovf;
    end
  end
`else
  logic unused_carry_s;

  assign sat_s          = 1'b0;
  assign unused_carry_s = carry_s[DIGITS-1];
  assign ovf            = 1'b0;
`endif

  // Result latch and one-cycle valid pulse
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      freq_bcd <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= terminal_s;
      if (terminal_s) begin
        freq_bcd <= next_cnt_s;
      end else begin
        freq_bcd <= freq_bcd;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: default instance plus a long-gate instance for overflow.
module tb_freq_meter;

  logic        clk_in;
  logic        rst_n;
  logic        rst2_n;
  logic        sig_in;
  logic        sig2_in;
  logic [15:0] freq_bcd;
  logic [15:0] freq2_bcd;
  logic        valid;
  logic        valid2;
  logic        ovf;
  logic        ovf2;

  int   mode;
  logic manual_val;
  int   cyc;
  int   pass_cnt;
  int   fail_cnt;
  int   chk_cnt;

  freq_meter #(.GATE_CYCLES(100), .DIGITS(4)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .freq_bcd (freq_bcd),
    .valid    (valid),
    .ovf      (ovf)
  );

  freq_meter #(.GATE_CYCLES(30000), .DIGITS(4)) dut2 (
    .clk_in   (clk_in),
    .rst_n    (rst2_n),
    .sig_in   (sig2_in),
    .freq_bcd (freq2_bcd),
    .valid    (valid2),
    .ovf      (ovf2)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Stimulus generator: updates inputs 1 time unit after each rising clock edge
  initial begin
    sig_in  = 1'b0;
    sig2_in = 1'b0;
    cyc     = 0;
    forever begin
      @(posedge clk_in);
      cyc++;
      #1;
      sig2_in = ~sig2_in;
      case (mode)
        1:       sig_in = ((cyc % 10) < 5);
        2:       sig_in = ~sig_in;
        3:       sig_in = manual_val;
        default: sig_in = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
  endtask

  // Returns the number of rising clock edges until valid is seen (or budget)
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    forever begin
      @(posedge clk_in);
      n++;
      @(negedge clk_in);
      if (valid || n >= budget) break;
    end
  endtask

  initial begin
    int n;
    int seen;
    int t;
    pass_cnt   = 0;
    fail_cnt   = 0;
    chk_cnt    = 0;
    mode       = 0;
    manual_val = 1'b0;
    rst_n      = 1'b0;
    rst2_n     = 1'b0;

    repeat (3) @(negedge clk_in);
    check("rst_freq",  {16'd0, freq_bcd}, 32'h0);
    check("rst_valid", {31'd0, valid},    32'h0);
    check("rst_ovf",   {31'd0, ovf},      32'h0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // Idle input: first valid after the 100th edge, pulse lasts one cycle
    wait_valid(200, n);
    check("t1_first_valid", n, 32'd100);
    check("t1_freq", {16'd0, freq_bcd}, 32'h0);
    check("t1_ovf",  {31'd0, ovf},      32'h0);
    cycles(1);
    check("t1_pulse_width", {31'd0, valid}, 32'h0);
    wait_valid(200, n);
    check("t1_period", n, 32'd99);
    check("t1_freq2", {16'd0, freq_bcd}, 32'h0);

    // Period-10 square wave: 10 edges per window (9->10 carry)
    mode = 1;
    wait_valid(200, n);
    wait_valid(200, n);
    check("t2_period", n, 32'd100);
    check("t2_freq_a", {16'd0, freq_bcd}, 32'h0010);
    wait_valid(200, n);
    check("t2_freq_b", {16'd0, freq_bcd}, 32'h0010);

    // Toggle every cycle: 50 edges per window
    mode = 2;
    wait_valid(200, n);
    wait_valid(200, n);
    check("t3_freq_a", {16'd0, freq_bcd}, 32'h0050);
    wait_valid(200, n);
    check("t3_freq_b", {16'd0, freq_bcd}, 32'h0050);
    check("t3_ovf", {31'd0, ovf}, 32'h0);

    // Single rise landing exactly in the terminal cycle
    mode = 3;
    manual_val = 1'b0;
    wait_valid(200, n);
    wait_valid(200, n);
    check("t5_quiet", {16'd0, freq_bcd}, 32'h0);
    cycles(97);
    manual_val = 1'b1;
    wait_valid(200, n);
    check("t5_latency", n, 32'd3);
    check("t5_term_edge", {16'd0, freq_bcd}, 32'h0001);
    manual_val = 1'b0;
    wait_valid(200, n);
    check("t5_next_window", {16'd0, freq_bcd}, 32'h0);

    // Reset mid-window with a period-10 wave, released when the wave is low
    mode = 1;
    wait_valid(200, n);
    wait_valid(200, n);
    check("t6_pre_freq", {16'd0, freq_bcd}, 32'h0010);
    cycles(40);
    t = 0;
    while ((cyc % 10) != 2 && t < 20) begin
      @(negedge clk_in);
      t++;
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_freq",  {16'd0, freq_bcd}, 32'h0);
    check("t6_rst_valid", {31'd0, valid},    32'h0);
    check("t6_rst_ovf",   {31'd0, ovf},      32'h0);
    cycles(3);
    check("t6_rst_hold", {16'd0, freq_bcd}, 32'h0);
    rst_n = 1'b1;
    wait_valid(200, n);
    check("t6_period", n, 32'd100);
    check("t6_freq", {16'd0, freq_bcd}, 32'h0010);

    // Long gate, toggle every cycle: 15000 edges in the second window
    seen = 0;
    t = 0;
    while (seen < 2 && t < 70000) begin
      @(negedge clk_in);
      t++;
      if (valid2) seen++;
    end
    check("t4_windows", seen, 32'd2);
`ifdef FREQ_METER_OVF_EN
    check("t4_freq", {16'd0, freq2_bcd}, 32'h9999);
    check("t4_ovf",  {31'd0, ovf2},      32'h1);
`else
    check("t4_freq", {16'd0, freq2_bcd}, 32'h5000);
    check("t4_ovf",  {31'd0, ovf2},      32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated edge-counting frequency meter for the counter experiments. It synchronises an external square wave `sig_in` to `clk_in` and counts its rising edges over a fixed gate window of `GATE_CYCLES` clock cycles. At the end of each window it latches the count as packed BCD for the seven-segment display path. It is the measuring counterpart of the clock divider: with the default 100 Hz system clock and `GATE_CYCLES = 100`, the result reads directly in Hz.

## Interface
Parameters:
- `GATE_CYCLES`, default 100: gate window length in `clk_in` cycles; must be ≥ 2.
- `DIGITS`, default 4: number of BCD digits in the result.

Ports:
- `clk_in`  input  1  system clock; the single clock of the block.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `sig_in`  input  1  asynchronous signal under measurement; measurable only below f(`clk_in`)/2.
- `freq_bcd`  output  4*DIGITS  latched edge count of the last completed window, packed BCD, most significant digit in the top nibble.
- `valid`  output  1  one-cycle pulse, high in the cycle in which `freq_bcd` has just been updated.
- `ovf`  output  1  count for the last window exceeded 10^DIGITS−1 (see Configuration).

## Operation
- **Synchroniser:** two flops, `s1 <= sig_in` and `s2 <= s1`, both reset to 0.
- **Edge detect:** `rise = s1 & ~s2`, combinational.
  - Because both flops reset to 0, a `sig_in` held high through reset release counts as one edge in the first window.
- **Gate counter:** runs from 0 to GATE_CYCLES−1 and wraps to 0. Width is $clog2(GATE_CYCLES). Reset value is 0.
  - "Terminal" means gate counter == GATE_CYCLES−1.
- **Edge counter:** DIGITS cascaded BCD digits, reset to 0.
  - `next_cnt` = BCD increment of the current count when `rise` is high, otherwise the current count.
  - Digit i carries into digit i+1 when digit i is 9 and the increment reaches it.
  - Digits never hold values A–F.
- **Non-terminal cycle:** edge counter <= `next_cnt`.
- **Terminal cycle:**
  - `freq_bcd` <= `next_cnt`, so an edge in the terminal cycle belongs to the closing window.
  - Edge counter <= 0, so no edge is lost or double-counted across the boundary.
  - `valid` <= 1.
- **Other cycles:** `valid` <= 0.
- **Reset values:** `freq_bcd` = 0, `valid` = 0, `ovf` = 0, all counters 0, `s1`/`s2` = 0.
- **Reset mid-window:** the partial count is discarded, outputs clear immediately (asynchronously), and a full new window starts from gate counter 0.

## Timing
- The gate counter holds 0 at reset release. `valid` is high after the GATE_CYCLES-th rising edge of `clk_in`, then once every GATE_CYCLES cycles.
- `freq_bcd` changes only in the same cycles that `valid` rises, and holds between updates.
- An edge on `sig_in` reaches the count 2–3 cycles after it occurs (synchroniser latency). Edges within 2 cycles of a window boundary may fall into either window.

## Configuration
- **`FREQ_METER_OVF_EN` defined:**
  - The edge counter saturates at all-nines.
  - A sticky in-window overflow bit sets when `rise` arrives while the count is all-nines.
  - At terminal, `ovf` <= overflow bit (including a terminal-cycle overflow), and the overflow bit clears.
  - `freq_bcd` then reads all-nines.
- **`FREQ_METER_OVF_EN` undefined:**
  - The count wraps modulo 10^DIGITS.
  - `ovf` is tied to 0.
  - No overflow logic is present.

## Structure
- **Shared package `freq_meter_pkg`:**
  - BCD digit width constant, 4.
  - Constant for the BCD max digit, 9.
  - Default GATE_CYCLES.
- **Sub-module `bcd_digit`:** one decade counter with inputs `clk_in`, `rst_n`, `clr`, `inc`, `sat`, and outputs `q[3:0]`, `carry`.
  - `freq_meter` instantiates DIGITS copies in a generate loop.
  - The top level holds the synchroniser, gate counter, result latch and overflow logic.

## Test plan
1. `sig_in` = 0 constantly, defaults -> `valid` after edge 100, 200, 300…; `freq_bcd` = 0x0000; `ovf` = 0.
2. `sig_in` square wave with period 10 cycles, defaults -> from the second window on, `freq_bcd` = 0x0010 each window (exercises the 9→10 carry).
3. `sig_in` toggling every cycle, defaults -> `freq_bcd` = 0x0050 in steady state.
4. `GATE_CYCLES` = 30000, `sig_in` toggling every cycle:
   - With `FREQ_METER_OVF_EN`: `freq_bcd` = 0x9999 and `ovf` = 1.
   - Without: `freq_bcd` = 0x5000 and `ovf` = 0.
5. A single synchronised `rise` arriving exactly in the terminal cycle -> counted in the closing window's `freq_bcd`; the next window starts at 0.
6. Square wave with period 10; `rst_n` low at cycle 150 for 3 cycles -> all outputs 0 during reset; next `valid` exactly 100 edges after release; count reflects the full post-reset window.
